// File: rtl/dmem_io_unit_pkg.sv
// Shared constants and decode helpers for the data-memory / memory-mapped I/O subsystem.
package dmem_io_unit_pkg;

   localparam int          DATA_W    = 16;
   localparam logic [15:0] OFS_OUT   = 16'd0;
   localparam logic [15:0] OFS_IN    = 16'd2;
   localparam logic [15:0] OFS_TCNT  = 16'd4;
   localparam logic [15:0] OFS_TCMP  = 16'd6;
   localparam logic [15:0] OFS_STAT  = 16'd8;
   localparam int          MATCH_BIT = 0;
   localparam logic [15:0] TCMP_RST  = 16'hFFFF;

   typedef enum logic [2:0] {
      SEL_NONE,
      SEL_RAM,
      SEL_OUT,
      SEL_IN,
      SEL_TCNT,
      SEL_TCMP,
      SEL_STAT
   } sel_e;

   // Word-granular match of a byte address against one I/O register.
   function automatic logic io_hit(input logic [15:0] addr,
                                   input logic [15:0] base,
                                   input logic [15:0] ofs);
      logic [15:0] reg_addr;
      reg_addr = base + ofs;
      return addr[15:1] == reg_addr[15:1];
   endfunction

endpackage

// File: rtl/dmem_io_unit_timer.sv
// Prescaled 16-bit timer with compare register and sticky match flag.
module io_timer
   import dmem_io_unit_pkg::*;
#(
   parameter int PRESCALE = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [DATA_W-1:0] wdata,
   input  logic              tcnt_we,
   input  logic              tcmp_we,
   input  logic              match_clr,
   output logic [DATA_W-1:0] tcnt,
   output logic [DATA_W-1:0] tcmp,
   output logic              match
);

   localparam logic [15:0] PCNT_MAX = 16'(PRESCALE - 1);

   logic [15:0]       pcnt_q, pcnt_d;
   logic [DATA_W-1:0] tcnt_q, tcnt_d;
   logic [DATA_W-1:0] tcmp_q, tcmp_d;
   logic              match_q, match_d;
   logic              tick;
   logic              match_set;

   // Next-state: a CPU write to TCNT overrides the tick and restarts the prescaler.
   always_comb begin
      tick      = (pcnt_q == PCNT_MAX);
      pcnt_d    = pcnt_q;
      tcnt_d    = tcnt_q;
      match_set = 1'b0;
      if (tcnt_we) begin
         tcnt_d = wdata;
         pcnt_d = 16'd0;
      end else if (tick) begin
         pcnt_d = 16'd0;
         if (tcnt_q == tcmp_q) begin
            tcnt_d    = 16'd0;
            match_set = 1'b1;
         end else begin
            tcnt_d = tcnt_q + 16'd1;
         end
      end else begin
         pcnt_d = pcnt_q + 16'd1;
      end

      if (tcmp_we) begin
         tcmp_d = wdata;
      end else begin
         tcmp_d = tcmp_q;
      end

      // Set wins over a simultaneous write-1-to-clear.
      if (match_set) begin
         match_d = 1'b1;
      end else if (match_clr) begin
         match_d = 1'b0;
      end else begin
         match_d = match_q;
      end
   end

   // Timer state registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         pcnt_q  <= 16'd0;
         tcnt_q  <= 16'd0;
         tcmp_q  <= TCMP_RST;
         match_q <= 1'b0;
      end else begin
         pcnt_q  <= pcnt_d;
         tcnt_q  <= tcnt_d;
         tcmp_q  <= tcmp_d;
         match_q <= match_d;
      end
   end

   assign tcnt  = tcnt_q;
   assign tcmp  = tcmp_q;
   assign match = match_q;

endmodule

// File: rtl/dmem_io_unit.sv
// Data RAM plus memory-mapped I/O page (OUT, synchronized IN, timer, STATUS) behind the core's MEM stage.
module dmem_io_unit
   import dmem_io_unit_pkg::*;
#(
   parameter int          RAM_AW   = 7,
   parameter int          PRESCALE = 4,
   parameter logic [15:0] IO_BASE  = 16'hFF00
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [15:0]       dmemaddr,
   input  logic [DATA_W-1:0] dmemwdata,
   input  logic              dmemwrite,
   input  logic              dmemread,
   output logic [DATA_W-1:0] dmemrdata,
   input  logic [DATA_W-1:0] inport,
   output logic [DATA_W-1:0] outport,
   output logic              timer_irq,
   output logic              bad_access
);

   logic [DATA_W-1:0] mem_q [0:(1<<RAM_AW)-1];
   logic [RAM_AW-1:0] ram_idx;
   sel_e              sel;

   logic [DATA_W-1:0] out_q, out_d;
   logic [DATA_W-1:0] in_meta_q, in_sync_q;
   logic              bad_q, bad_d;

   logic [DATA_W-1:0] tcnt, tcmp;
   logic              match;
   logic              tcnt_we, tcmp_we, match_clr;
   logic [DATA_W-1:0] stat;

   assign ram_idx = dmemaddr[RAM_AW:1];

   // Address decode on the word address; RAM sits at the bottom of the map.
   always_comb begin
      if (dmemaddr[15:RAM_AW+1] == {(15-RAM_AW){1'b0}}) begin
         sel = SEL_RAM;
      end else if (io_hit(dmemaddr, IO_BASE, OFS_OUT)) begin
         sel = SEL_OUT;
      end else if (io_hit(dmemaddr, IO_BASE, OFS_IN)) begin
         sel = SEL_IN;
      end else if (io_hit(dmemaddr, IO_BASE, OFS_TCNT)) begin
         sel = SEL_TCNT;
      end else if (io_hit(dmemaddr, IO_BASE, OFS_TCMP)) begin
         sel = SEL_TCMP;
      end else if (io_hit(dmemaddr, IO_BASE, OFS_STAT)) begin
         sel = SEL_STAT;
      end else begin
         sel = SEL_NONE;
      end
   end

   // Combinational read mux and write strobes.
   always_comb begin
      stat            = {DATA_W{1'b0}};
      stat[MATCH_BIT] = match;
      dmemrdata       = {DATA_W{1'b0}};
      if (dmemread) begin
         case (sel)
            SEL_RAM:  dmemrdata = mem_q[ram_idx];
            SEL_OUT:  dmemrdata = out_q;
            SEL_IN:   dmemrdata = in_sync_q;
            SEL_TCNT: dmemrdata = tcnt;
            SEL_TCMP: dmemrdata = tcmp;
            SEL_STAT: dmemrdata = stat;
            default:  dmemrdata = {DATA_W{1'b0}};
         endcase
      end else begin
         dmemrdata = {DATA_W{1'b0}};
      end

      tcnt_we   = dmemwrite && (sel == SEL_TCNT);
      tcmp_we   = dmemwrite && (sel == SEL_TCMP);
      match_clr = dmemwrite && (sel == SEL_STAT) && dmemwdata[MATCH_BIT];

      if (dmemwrite && (sel == SEL_OUT)) begin
         out_d = dmemwdata;
      end else begin
         out_d = out_q;
      end

      bad_d = (dmemread || dmemwrite) && (sel == SEL_NONE);
   end

   // RAM write port; no reset on contents, but a write coinciding with reset is dropped.
   always_ff @(posedge clock) begin
      if (!reset && dmemwrite && (sel == SEL_RAM)) begin
         mem_q[ram_idx] <= dmemwdata;
      end
   end

   // OUT register, IN two-flop synchronizer and bad-access pulse.
   always_ff @(posedge clock) begin
      if (reset) begin
         out_q     <= {DATA_W{1'b0}};
         in_meta_q <= {DATA_W{1'b0}};
         in_sync_q <= {DATA_W{1'b0}};
         bad_q     <= 1'b0;
      end else begin
         out_q     <= out_d;
         in_meta_q <= inport;
         in_sync_q <= in_meta_q;
         bad_q     <= bad_d;
      end
   end

   io_timer #(
      .PRESCALE (PRESCALE)
   ) u_timer (
      .clock     (clock),
      .reset     (reset),
      .wdata     (dmemwdata),
      .tcnt_we   (tcnt_we),
      .tcmp_we   (tcmp_we),
      .match_clr (match_clr),
      .tcnt      (tcnt),
      .tcmp      (tcmp),
      .match     (match)
   );

   assign outport    = out_q;
   assign timer_irq  = match;
   assign bad_access = bad_q;

endmodule

// File: tb/tb_dmem_io_unit.sv
// Directed self-checking bench for dmem_io_unit (RAM_AW=7, PRESCALE=4, IO_BASE=16'hFF00).
module tb_dmem_io_unit;

   logic        clock;
   logic        reset;
   logic [15:0] dmemaddr;
   logic [15:0] dmemwdata;
   logic        dmemwrite;
   logic        dmemread;
   logic [15:0] dmemrdata;
   logic [15:0] inport;
   logic [15:0] outport;
   logic        timer_irq;
   logic        bad_access;

   int n_cmp;
   int n_err;

   localparam logic [15:0] A_OUT  = 16'hFF00;
   localparam logic [15:0] A_IN   = 16'hFF02;
   localparam logic [15:0] A_TCNT = 16'hFF04;
   localparam logic [15:0] A_TCMP = 16'hFF06;
   localparam logic [15:0] A_STAT = 16'hFF08;

   dmem_io_unit #(
      .RAM_AW   (7),
      .PRESCALE (4),
      .IO_BASE  (16'hFF00)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .dmemaddr   (dmemaddr),
      .dmemwdata  (dmemwdata),
      .dmemwrite  (dmemwrite),
      .dmemread   (dmemread),
      .dmemrdata  (dmemrdata),
      .inport     (inport),
      .outport    (outport),
      .timer_irq  (timer_irq),
      .bad_access (bad_access)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic step_n(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic wr(input logic [15:0] a, input logic [15:0] d);
      dmemaddr  = a;
      dmemwdata = d;
      dmemwrite = 1'b1;
      dmemread  = 1'b0;
      step();
      dmemwrite = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input logic [15:0] a, input logic [15:0] exp);
      dmemaddr  = a;
      dmemwrite = 1'b0;
      dmemread  = 1'b1;
      #1;
      check_val(tag, dmemrdata, exp);
      dmemread  = 1'b0;
   endtask

   initial begin
      n_cmp     = 0;
      n_err     = 0;
      reset     = 1'b1;
      dmemaddr  = 16'h0000;
      dmemwdata = 16'h0000;
      dmemwrite = 1'b0;
      dmemread  = 1'b0;
      inport    = 16'h0000;
      step_n(2);
      reset = 1'b0;

      // Reset state
      check_val("rst_outport", outport, 16'h0000);
      check_val("rst_irq", {15'd0, timer_irq}, 16'h0000);
      check_val("rst_bad", {15'd0, bad_access}, 16'h0000);
      rd_chk("rst_tcnt", A_TCNT, 16'h0000);
      rd_chk("rst_tcmp", A_TCMP, 16'hFFFF);
      rd_chk("rst_stat", A_STAT, 16'h0000);

      // RAM write/read, same-cycle old value, read disabled
      wr(16'h0010, 16'hBEEF);
      rd_chk("ram_rd", 16'h0010, 16'hBEEF);
      dmemaddr  = 16'h0010;
      dmemwdata = 16'hCAFE;
      dmemwrite = 1'b1;
      dmemread  = 1'b1;
      #1;
      check_val("ram_wr_rd_old", dmemrdata, 16'hBEEF);
      step();
      dmemwrite = 1'b0;
      dmemread  = 1'b0;
      rd_chk("ram_rd_new", 16'h0010, 16'hCAFE);
      dmemaddr = 16'h0010;
      dmemread = 1'b0;
      #1;
      check_val("ram_rd_dis", dmemrdata, 16'h0000);
      wr(16'h00FE, 16'h1111);
      rd_chk("ram_top_word", 16'h00FE, 16'h1111);
      rd_chk("ram_addr_bit0", 16'h0011, 16'hCAFE);

      // Output port
      wr(A_OUT, 16'h00A5);
      check_val("outport", outport, 16'h00A5);
      rd_chk("out_rd", A_OUT, 16'h00A5);

      // Input synchronizer: two-cycle visibility
      inport = 16'h1234;
      rd_chk("in_c0", A_IN, 16'h0000);
      step();
      rd_chk("in_c1", A_IN, 16'h0000);
      step();
      rd_chk("in_c2", A_IN, 16'h1234);
      wr(A_IN, 16'hFFFF);
      check_val("in_wr_nobad", {15'd0, bad_access}, 16'h0000);
      rd_chk("in_wr_ign", A_IN, 16'h1234);

      // Unmapped read
      dmemaddr = 16'h8000;
      dmemread = 1'b1;
      #1;
      check_val("unm_rd_data", dmemrdata, 16'h0000);
      step();
      dmemread = 1'b0;
      check_val("unm_bad_hi", {15'd0, bad_access}, 16'h0001);
      step();
      check_val("unm_bad_lo", {15'd0, bad_access}, 16'h0000);

      // Back-to-back bad accesses at the first address past RAM
      dmemaddr = 16'h0100;
      dmemread = 1'b1;
      step();
      check_val("b2b_bad_1", {15'd0, bad_access}, 16'h0001);
      step();
      check_val("b2b_bad_2", {15'd0, bad_access}, 16'h0001);
      dmemread = 1'b0;
      step();
      check_val("b2b_bad_end", {15'd0, bad_access}, 16'h0000);

      // Unmapped write
      wr(16'hFF0A, 16'h1234);
      check_val("unm_wr_bad", {15'd0, bad_access}, 16'h0001);
      check_val("unm_wr_out", outport, 16'h00A5);
      step();
      check_val("unm_wr_bad_lo", {15'd0, bad_access}, 16'h0000);

      // Timer match: TCMP=3, TCNT=0 -> match 16 cycles after the TCNT write
      wr(A_TCMP, 16'h0003);
      wr(A_TCNT, 16'h0000);
      step_n(15);
      rd_chk("tm_tcnt_15", A_TCNT, 16'h0003);
      check_val("tm_irq_15", {15'd0, timer_irq}, 16'h0000);
      step();
      rd_chk("tm_tcnt_16", A_TCNT, 16'h0000);
      check_val("tm_irq_16", {15'd0, timer_irq}, 16'h0001);
      rd_chk("tm_stat_set", A_STAT, 16'h0001);
      wr(A_STAT, 16'h0001);
      check_val("tm_clr", {15'd0, timer_irq}, 16'h0000);
      rd_chk("tm_stat_clr", A_STAT, 16'h0000);
      step_n(14);
      wr(A_STAT, 16'h0001);
      check_val("tm_clr_vs_set", {15'd0, timer_irq}, 16'h0001);
      rd_chk("tm_tcnt_32", A_TCNT, 16'h0000);
      wr(A_STAT, 16'h0001);
      check_val("tm_clr2", {15'd0, timer_irq}, 16'h0000);

      // Write beats tick: TCNT=5 written exactly on a tick edge
      wr(A_TCNT, 16'h0000);
      step_n(3);
      wr(A_TCNT, 16'h0005);
      rd_chk("pri_tcnt_wr", A_TCNT, 16'h0005);
      step_n(3);
      rd_chk("pri_tcnt_hold", A_TCNT, 16'h0005);
      step();
      rd_chk("pri_tcnt_inc", A_TCNT, 16'h0006);
      // Write mid-period restarts the prescaler
      step();
      wr(A_TCNT, 16'h0007);
      step_n(3);
      rd_chk("pcnt_rst_hold", A_TCNT, 16'h0007);
      step();
      rd_chk("pcnt_rst_inc", A_TCNT, 16'h0008);
      check_val("pri_irq", {15'd0, timer_irq}, 16'h0000);

      // Wrap: TCNT=FFFF, TCMP=0 -> 0 with no match
      wr(A_TCMP, 16'h0000);
      wr(A_TCNT, 16'hFFFF);
      step_n(3);
      rd_chk("wrap_pre", A_TCNT, 16'hFFFF);
      step();
      rd_chk("wrap_post", A_TCNT, 16'h0000);
      check_val("wrap_irq", {15'd0, timer_irq}, 16'h0000);

      // Reset mid-operation drops a RAM write in the same cycle
      dmemaddr  = 16'h0010;
      dmemwdata = 16'h5555;
      dmemwrite = 1'b1;
      reset     = 1'b1;
      step();
      reset     = 1'b0;
      dmemwrite = 1'b0;
      check_val("mid_rst_out", outport, 16'h0000);
      check_val("mid_rst_irq", {15'd0, timer_irq}, 16'h0000);
      rd_chk("mid_rst_ram", 16'h0010, 16'hCAFE);
      rd_chk("mid_rst_tcmp", A_TCMP, 16'hFFFF);
      rd_chk("mid_rst_tcnt", A_TCNT, 16'h0000);
      rd_chk("mid_rst_in", A_IN, 16'h0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
